flit_mux2: RTL and testbench

//   Two-input flit multiplexer for the NoC router datapath; characterised for energy.

---
 rtl/flit_mux2_if.sv | 43 ++++
 rtl/flit_mux2.sv | 110 +++++++++++
 tb/tb_flit_mux2.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/flit_mux2_if.sv
// ============================================================================
// Module      : flit_mux2_if
// Description : Bundle of the two input flit streams, the one-hot select and
//               the registered output flit of the two-input flit multiplexer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface flit_mux2_if #(
    parameter int DATA_W = 67,
    parameter int VCH_W  = 1,
    parameter int SEL_W  = 2
);
    logic [DATA_W-1:0] idata_0;
    logic              ivalid_0;
    logic [VCH_W-1:0]  ivch_0;
    logic [DATA_W-1:0] idata_1;
    logic              ivalid_1;
    logic [VCH_W-1:0]  ivch_1;
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] odata;
    logic              ovalid;
    logic [VCH_W-1:0]  ovch;
    logic              locked;

    // Traffic source / allocator side: drives inputs, observes the output.
    modport master (
        output idata_0, ivalid_0, ivch_0,
        output idata_1, ivalid_1, ivch_1,
        output sel,
        input  odata, ovalid, ovch, locked
    );

    // Multiplexer side.
    modport slave (
        input  idata_0, ivalid_0, ivch_0,
        input  idata_1, ivalid_1, ivch_1,
        input  sel,
        output odata, ovalid, ovch, locked
    );
endinterface

`default_nettype wire

// File: rtl/flit_mux2.sv
// ============================================================================
// Module      : flit_mux2
// Description : Two-input registered flit multiplexer with one-hot select.
//               Optional packet lock (wormhole-safe switching) is enabled by
//               defining the macro MUX_PKT_LOCK_EN; without it the block is a
//               pure registered mux and locked is tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module flit_mux2 #(
    parameter int DATA_W = 67,
    parameter int VCH_W  = 1,
    parameter int SEL_W  = 2
) (
    input  logic            clk,
    input  logic            rst,
    flit_mux2_if.slave      bus
);
    localparam logic [2:0] C_TYPE_HEAD = 3'b001;
    localparam logic [2:0] C_TYPE_TAIL = 3'b010;
    localparam logic [SEL_W-1:0] C_SEL_IN0 = SEL_W'(1);
    localparam logic [SEL_W-1:0] C_SEL_IN1 = SEL_W'(2);

    logic [DATA_W-1:0] odata_q;
    logic              ovalid_q;
    logic [VCH_W-1:0]  ovch_q;
    logic              locked_q, locked_d;
    logic              lock_port_q, lock_port_d;

    logic [SEL_W-1:0]  eff_sel;
    logic              pick_legal;
    logic              pick_port;
    logic [DATA_W-1:0] pick_data;
    logic              pick_valid;
    logic [VCH_W-1:0]  pick_vch;
    logic [2:0]        pick_type;

    // Resolve effective select (lock overrides sel) and pick the source stream.
    always_comb begin
        eff_sel = locked_q ? (lock_port_q ? C_SEL_IN1 : C_SEL_IN0) : bus.sel;
        pick_legal = 1'b1;
        pick_port  = 1'b0;
        pick_data  = bus.idata_0;
        pick_valid = bus.ivalid_0;
        pick_vch   = bus.ivch_0;
        if (eff_sel == C_SEL_IN0) begin
            pick_port = 1'b0;
        end else if (eff_sel == C_SEL_IN1) begin
            pick_port  = 1'b1;
            pick_data  = bus.idata_1;
            pick_valid = bus.ivalid_1;
            pick_vch   = bus.ivch_1;
        end else begin
            pick_legal = 1'b0;
        end
        pick_type = pick_data[DATA_W-1:DATA_W-3];
    end

`ifdef MUX_PKT_LOCK_EN
    // Packet lock: a forwarded HEAD grabs the port, the matching TAIL releases it.
    always_comb begin
        locked_d    = locked_q;
        lock_port_d = lock_port_q;
        if (pick_legal && pick_valid) begin
            if (pick_type == C_TYPE_HEAD && !locked_q) begin
                locked_d    = 1'b1;
                lock_port_d = pick_port;
            end else if (pick_type == C_TYPE_TAIL && locked_q) begin
                locked_d    = 1'b0;
            end
        end
    end
`else
    // No packet lock: the select is honoured every cycle.
    always_comb begin
        locked_d    = 1'b0;
        lock_port_d = 1'b0;
    end
`endif

    // Output and lock registers; an illegal select drops valid but holds data/VC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            odata_q     <= '0;
            ovalid_q    <= 1'b0;
            ovch_q      <= '0;
            locked_q    <= 1'b0;
            lock_port_q <= 1'b0;
        end else begin
            locked_q    <= locked_d;
            lock_port_q <= lock_port_d;
            if (pick_legal) begin
                odata_q  <= pick_data;
                ovalid_q <= pick_valid;
                ovch_q   <= pick_vch;
            end else begin
                ovalid_q <= 1'b0;
            end
        end
    end

    assign bus.odata  = odata_q;
    assign bus.ovalid = ovalid_q;
    assign bus.ovch   = ovch_q;
    assign bus.locked = locked_q;

endmodule

`default_nettype wire

// File: tb/tb_flit_mux2.sv
// ============================================================================
// Module      : tb_flit_mux2
// Description : Self-checking bench for flit_mux2 with a cycle-level
//               reference model of the forwarding and packet-lock rules.
//               Follows MUX_PKT_LOCK_EN like the design does.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_flit_mux2;
    localparam int DATA_W = 67;
    localparam int VCH_W  = 1;
    localparam logic [2:0] T_NONE = 3'b000;
    localparam logic [2:0] T_HEAD = 3'b001;
    localparam logic [2:0] T_TAIL = 3'b010;
    localparam logic [2:0] T_HT   = 3'b011;
    localparam logic [2:0] T_DATA = 3'b100;

    logic clk = 1'b0;
    logic rst = 1'b0;
    flit_mux2_if #(.DATA_W(DATA_W), .VCH_W(VCH_W), .SEL_W(2)) bus ();

    flit_mux2 #(.DATA_W(DATA_W), .VCH_W(VCH_W), .SEL_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state: what the outputs must show after the next edge.
    logic [DATA_W-1:0] m_odata;
    logic              m_ovalid;
    logic [VCH_W-1:0]  m_ovch;
    logic              m_locked;
    int                m_port;

    function automatic logic [DATA_W-1:0] mk_flit(input logic [2:0] t);
        return {t, $urandom(), $urandom()};
    endfunction

    task automatic model_reset();
        m_odata = '0; m_ovalid = 1'b0; m_ovch = '0; m_locked = 1'b0; m_port = 0;
    endtask

    // One clock edge of the behaviour, from the currently applied inputs.
    task automatic model_edge();
        int p;
        logic [DATA_W-1:0] d[2];
        logic              v[2];
        logic [VCH_W-1:0]  c[2];
        logic [2:0]        t;
        d[0] = bus.idata_0; v[0] = bus.ivalid_0; c[0] = bus.ivch_0;
        d[1] = bus.idata_1; v[1] = bus.ivalid_1; c[1] = bus.ivch_1;
        if (m_locked)             p = m_port;
        else if (bus.sel == 2'b01) p = 0;
        else if (bus.sel == 2'b10) p = 1;
        else                       p = -1;
        if (p < 0) begin
            m_ovalid = 1'b0;
        end else begin
            m_odata  = d[p];
            m_ovch   = c[p];
            m_ovalid = v[p];
`ifdef MUX_PKT_LOCK_EN
            t = d[p][DATA_W-1 -: 3];
            if (v[p]) begin
                if (t == T_HEAD && !m_locked) begin
                    m_locked = 1'b1;
                    m_port   = p;
                end else if (t == T_TAIL && m_locked) begin
                    m_locked = 1'b0;
                end
            end
`else
            t = '0;
`endif
        end
    endtask

    task automatic check(input string tag);
        n_assert++;
        assert (bus.odata === m_odata) else begin
            n_fail++;
            $error("FAIL %s odata observed=%h expected=%h", tag, bus.odata, m_odata);
        end
        n_assert++;
        assert (bus.ovalid === m_ovalid) else begin
            n_fail++;
            $error("FAIL %s ovalid observed=%b expected=%b", tag, bus.ovalid, m_ovalid);
        end
        n_assert++;
        assert (bus.ovch === m_ovch) else begin
            n_fail++;
            $error("FAIL %s ovch observed=%h expected=%h", tag, bus.ovch, m_ovch);
        end
        n_assert++;
        assert (bus.locked === m_locked) else begin
            n_fail++;
            $error("FAIL %s locked observed=%b expected=%b", tag, bus.locked, m_locked);
        end
    endtask

    // Apply inputs are already stable; advance one edge and compare.
    task automatic step(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check(tag);
    endtask

    task automatic drive(input int port, input logic valid, input logic [2:0] t,
                         input logic [VCH_W-1:0] vch);
        if (port == 0) begin
            bus.idata_0 = mk_flit(t); bus.ivalid_0 = valid; bus.ivch_0 = vch;
        end else begin
            bus.idata_1 = mk_flit(t); bus.ivalid_1 = valid; bus.ivch_1 = vch;
        end
    endtask

    task automatic drive_rand(input int port);
        logic [2:0] t;
        t = 3'($urandom_range(0, 4));
        drive(port, 1'($urandom_range(0, 1)), t, VCH_W'($urandom_range(0, 1)));
    endtask

    // Asynchronous reset between edges; outputs must clear without a clock edge.
    task automatic async_reset(input string tag);
        #1 rst = 1'b1;
        drive_rand(0); drive_rand(1);
        bus.sel = 2'($urandom_range(0, 3));
        #1;
        model_reset();
        check(tag);
        @(posedge clk);
        #1;
        check({tag, "_hold"});
        rst = 1'b0;
    endtask

    initial begin
        int cnt;
        model_reset();
        bus.sel = 2'b00;
        drive_rand(0); drive_rand(1);

        // Reset at power-up, applied between clock edges.
        #2 rst = 1'b1;
        #1 check("reset_async");
        @(posedge clk); #1;
        check("reset_held");
        rst = 1'b0;

        // Select input 1 with a known flit.
        bus.sel = 2'b10;
        drive_rand(0);
        bus.idata_1 = {T_HEAD, 32'h0, 32'h4}; bus.ivalid_1 = 1'b1; bus.ivch_1 = 1'b1;
        step("sel_in1");
        n_assert++;
        assert (bus.odata === {T_HEAD, 32'h0, 32'h4} && bus.ovalid === 1'b1 && bus.ovch === 1'b1) else begin
            n_fail++;
            $error("FAIL sel_in1_const odata=%h ovalid=%b ovch=%b expected HEAD/4,1,1",
                   bus.odata, bus.ovalid, bus.ovch);
        end

        // Reset mid-packet clears outputs and any lock immediately.
        async_reset("reset_midpkt");

        // Packet stream on input 1; input 0 carries random noise.
        bus.sel = 2'b10;
        for (int pk = 0; pk < 10; pk++) begin
            cnt = 0;
            for (int i = 0; i < 29; i++) begin
                drive_rand(0);
                if (i == 0)       drive(1, 1'b1, T_HEAD, VCH_W'(pk % 2));
                else if (i <= 20) drive(1, 1'b1, T_DATA, VCH_W'(pk % 2));
                else if (i == 21) drive(1, 1'b1, T_TAIL, VCH_W'(pk % 2));
                else              drive(1, 1'b0, T_NONE, VCH_W'($urandom_range(0, 1)));
                step("stream");
                if (bus.ovalid === 1'b1) cnt++;
            end
            n_assert++;
            assert (cnt == 22) else begin
                n_fail++;
                $error("FAIL stream_count packet=%0d observed=%0d expected=22", pk, cnt);
            end
        end

        // Illegal selects: valid drops, data and VC hold.
        drive(0, 1'b1, T_DATA, 1'b1); drive(1, 1'b1, T_DATA, 1'b0);
        bus.sel = 2'b00;
        for (int i = 0; i < 3; i++) begin
            step("illegal_00");
            drive_rand(0); drive(1, 1'b1, T_DATA, 1'b1);
        end
        bus.sel = 2'b11;
        for (int i = 0; i < 3; i++) begin
            step("illegal_11");
            drive_rand(0); drive_rand(1);
        end

        // Packet on in0, then sel moves to in1 mid-packet.
        bus.sel = 2'b01;
        drive(0, 1'b1, T_HEAD, 1'b0); drive(1, 1'b1, T_DATA, 1'b1);
        step("lock_head");
        drive(0, 1'b1, T_DATA, 1'b0);
        step("lock_data0");
        bus.sel = 2'b10;
        for (int i = 0; i < 3; i++) begin
            drive(0, 1'b1, T_DATA, 1'b0); drive(1, 1'b1, T_DATA, 1'b1);
            step("lock_switch");
        end
        drive(0, 1'b1, T_TAIL, 1'b0); drive(1, 1'b1, T_DATA, 1'b1);
        step("lock_tail");
        for (int i = 0; i < 3; i++) begin
            drive(0, 1'b1, T_DATA, 1'b0); drive(1, 1'b1, T_DATA, 1'b1);
            step("after_tail");
        end
        // HEADTAIL never locks; the next cycle must follow sel.
        bus.sel = 2'b01;
        drive(0, 1'b1, T_HT, 1'b1); drive(1, 1'b1, T_DATA, 1'b0);
        step("headtail");
        bus.sel = 2'b10;
        drive(0, 1'b1, T_DATA, 1'b1); drive(1, 1'b1, T_HEAD, 1'b0);
        step("headtail_next");
        // HEAD while locked keeps the lock; TAIL then releases.
        bus.sel = 2'b01;
        drive(0, 1'b1, T_DATA, 1'b1); drive(1, 1'b1, T_HEAD, 1'b1);
        step("head_relock");
        drive(0, 1'b1, T_DATA, 1'b1); drive(1, 1'b1, T_TAIL, 1'b1);
        step("head_tail_release");

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            bus.sel = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3))
                                                  : ($urandom_range(0, 1) ? 2'b10 : 2'b01);
            drive_rand(0); drive_rand(1);
            step("random");
            if (i == 200) async_reset("reset_random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Hard time limit so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

`default_nettype wire
